// File: rtl/uart_rx.sv
// UART receiver: synchronised rx line, mid-bit sampling, 8 data bits LSB first,
// optional parity, one stop bit. Registered byte plus error flags with a one-cycle valid strobe.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 1,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       parity_en,
  input  logic       even_parity,
  output logic [7:0] data_out,
  output logic       rx_valid,
  output logic       rx_busy,
  output logic       parity_err,
  output logic       frame_err
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned MID   = (CLKS_PER_BIT - 1) / 2;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;

  state_t             state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic               rx_s;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         shreg_q, shreg_d;
  logic               par_bit_q, par_bit_d;
  logic               pe_q, pe_d;
  logic               ep_q, ep_d;
  logic [7:0]         data_d;
  logic               valid_d, busy_d, perr_d, ferr_d;
  logic               sample_c;

  // Synchroniser resets to idle-high so reset never looks like a start bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '1;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
  end

  assign rx_s     = sync_q[SYNC_STAGES-1];
  assign sample_c = (cnt_q == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shreg_q    <= '0;
      par_bit_q  <= 1'b0;
      pe_q       <= 1'b0;
      ep_q       <= 1'b0;
      data_out   <= '0;
      rx_valid   <= 1'b0;
      rx_busy    <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shreg_q    <= shreg_d;
      par_bit_q  <= par_bit_d;
      pe_q       <= pe_d;
      ep_q       <= ep_d;
      data_out   <= data_d;
      rx_valid   <= valid_d;
      rx_busy    <= busy_d;
      parity_err <= perr_d;
      frame_err  <= ferr_d;
    end
  end

  // Next state: cnt_q counts down to the next sample edge, reloading a full bit period
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shreg_d   = shreg_q;
    par_bit_d = par_bit_q;
    pe_d      = pe_q;
    ep_d      = ep_q;
    data_d    = data_out;
    valid_d   = 1'b0;
    perr_d    = parity_err;
    ferr_d    = frame_err;

    if (state_q != IDLE && state_q != WAIT_HIGH)
      cnt_d = sample_c ? CNT_W'(CLKS_PER_BIT - 1) : cnt_q - CNT_W'(1);

    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          pe_d  = parity_en;
          ep_d  = even_parity;
          bit_d = '0;
          // With MID=0 the start bit is sampled at detection itself
          if (MID == 0) begin
            state_d = DATA;
            cnt_d   = CNT_W'(CLKS_PER_BIT - 1);
          end else begin
            state_d = START;
            cnt_d   = CNT_W'(MID - 1);
          end
        end
      end
      START: begin
        if (sample_c) state_d = rx_s ? IDLE : DATA;
      end
      DATA: begin
        if (sample_c) begin
          shreg_d = {rx_s, shreg_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = pe_q ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (sample_c) begin
          par_bit_d = rx_s;
          state_d   = STOP;
        end
      end
      STOP: begin
        if (sample_c) begin
          data_d  = shreg_q;
          perr_d  = pe_q & (par_bit_q != (ep_q ? ^shreg_q : ~^shreg_q));
          ferr_d  = ~rx_s;
          valid_d = 1'b1;
          state_d = rx_s ? IDLE : WAIT_HIGH;
        end
      end
      WAIT_HIGH: begin
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE) && (state_d != WAIT_HIGH);
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: two instances (1 and 16 clocks per bit) driven by a frame generator
// and checked every cycle against a sample-schedule model.
module tb_uart_rx;

  localparam int unsigned SYNC = 2;
  localparam int unsigned CPB0 = 1;
  localparam int unsigned CPB1 = 16;

  logic       clk;
  logic       rst;
  logic       rx [2];
  logic       parity_en;
  logic       even_parity;
  logic [7:0] dout [2];
  logic       valid [2];
  logic       busy [2];
  logic       perr [2];
  logic       ferr [2];

  uart_rx #(.CLKS_PER_BIT(CPB0), .SYNC_STAGES(SYNC)) u0 (
    .clk(clk), .rst(rst), .rx(rx[0]), .parity_en(parity_en), .even_parity(even_parity),
    .data_out(dout[0]), .rx_valid(valid[0]), .rx_busy(busy[0]),
    .parity_err(perr[0]), .frame_err(ferr[0])
  );

  uart_rx #(.CLKS_PER_BIT(CPB1), .SYNC_STAGES(SYNC)) u1 (
    .clk(clk), .rst(rst), .rx(rx[1]), .parity_en(parity_en), .even_parity(even_parity),
    .data_out(dout[1]), .rx_valid(valid[1]), .rx_busy(busy[1]),
    .parity_err(perr[1]), .frame_err(ferr[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model state: line history, frame mode (0 idle, 1 in frame, 2 waiting for high)
  int         cpb [2];
  bit         hist [2][SYNC];
  int         mode [2];
  int         t0 [2];
  bit         m_pe [2];
  bit         m_ep [2];
  logic [7:0] m_bits [2];
  bit         m_pbit [2];
  logic [7:0] e_data [2];
  bit         e_valid [2];
  bit         e_busy [2];
  bit         e_perr [2];
  bit         e_ferr [2];

  int cyc;
  int n_valid [2];
  int last_valid [2];
  int n_checks;
  int n_pass;

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < int'(SYNC); j++) hist[i][j] = 1'b1;
      mode[i]    = 0;
      e_data[i]  = 8'h00;
      e_valid[i] = 1'b0;
      e_busy[i]  = 1'b0;
      e_perr[i]  = 1'b0;
      e_ferr[i]  = 1'b0;
    end
  endfunction

  // Bit k of a frame is sampled at t0 + k*cpb + mid, using the line as seen SYNC edges late
  function automatic void model_edge(input int i, input bit rxv);
    bit rs;
    int mid, d, k, last;
    rs  = hist[i][SYNC-1];
    mid = (cpb[i] - 1) / 2;
    for (int j = int'(SYNC) - 1; j > 0; j--) hist[i][j] = hist[i][j-1];
    hist[i][0] = rxv;
    e_valid[i] = 1'b0;
    if (mode[i] == 2) begin
      if (rs) mode[i] = 0;
    end else begin
      if (mode[i] == 0 && !rs) begin
        mode[i] = 1;
        t0[i]   = cyc;
        m_pe[i] = parity_en;
        m_ep[i] = even_parity;
      end
      if (mode[i] == 1) begin
        d = cyc - t0[i] - mid;
        if (d >= 0 && (d % cpb[i]) == 0) begin
          k    = d / cpb[i];
          last = m_pe[i] ? 10 : 9;
          if (k == 0 && rs) mode[i] = 0;
          if (k >= 1 && k <= 8) m_bits[i][k-1] = rs;
          if (k == 9 && m_pe[i]) m_pbit[i] = rs;
          if (k == last) begin
            e_data[i]  = m_bits[i];
            e_perr[i]  = m_pe[i] && (m_pbit[i] != (m_ep[i] ? ^m_bits[i] : ~^m_bits[i]));
            e_ferr[i]  = !rs;
            e_valid[i] = 1'b1;
            mode[i]    = rs ? 0 : 2;
          end
        end
      end
    end
    e_busy[i] = (mode[i] == 1);
  endfunction

  task automatic compare(input int i);
    n_checks++;
    if (dout[i] === e_data[i] && valid[i] === e_valid[i] && busy[i] === e_busy[i] &&
        perr[i] === e_perr[i] && ferr[i] === e_ferr[i]) begin
      n_pass++;
    end else begin
      $display("FAIL cycle %0d u%0d outputs: got data=%02h valid=%0b busy=%0b perr=%0b ferr=%0b, expected data=%02h valid=%0b busy=%0b perr=%0b ferr=%0b",
               cyc, i, dout[i], valid[i], busy[i], perr[i], ferr[i],
               e_data[i], e_valid[i], e_busy[i], e_perr[i], e_ferr[i]);
    end
    if (valid[i] === 1'b1) begin
      n_valid[i]++;
      last_valid[i] = cyc;
    end
  endtask

  task automatic lit(input string name, input int got, input int expv);
    n_checks++;
    if (got == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, expv);
  endtask

  // One clock: drive lines, advance model on the edge, compare 1 time unit later
  task automatic step(input bit r0, input bit r1);
    rx[0] = r0;
    rx[1] = r1;
    @(posedge clk);
    cyc++;
    if (rst) begin
      model_reset();
    end else begin
      model_edge(0, r0);
      model_edge(1, r1);
    end
    #1;
    compare(0);
    compare(1);
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) step(1'b1, 1'b1);
  endtask

  task automatic drive_bit(input int i, input bit v);
    for (int c = 0; c < cpb[i]; c++) step(i == 0 ? v : 1'b1, i == 1 ? v : 1'b1);
  endtask

  // Full frame; parity inputs may be scrambled once the receiver has latched them
  task automatic send_frame(input int i, input logic [7:0] d, input bit pe, input bit ep,
                            input bit bad_par, input bit stop, input bit scramble,
                            output int start_cyc);
    bit b [11];
    int nb, fc;
    parity_en   = pe;
    even_parity = ep;
    b[0] = 1'b0;
    for (int j = 0; j < 8; j++) b[j+1] = d[j];
    nb = pe ? 11 : 10;
    if (pe) b[9] = (ep ? ^d : ~^d) ^ bad_par;
    b[nb-1] = stop;
    start_cyc = cyc + 1;
    fc = 0;
    for (int j = 0; j < nb; j++) begin
      for (int c = 0; c < cpb[i]; c++) begin
        if (scramble && fc >= 3) begin
          parity_en   = 1'($urandom_range(0, 1));
          even_parity = 1'($urandom_range(0, 1));
        end
        step(i == 0 ? b[j] : 1'b1, i == 1 ? b[j] : 1'b1);
        fc++;
      end
    end
  endtask

  initial begin
    int sc, v0, v1;
    logic [7:0] byte_c3, rd;
    bit rpe, rep, rbad;
    cpb[0]   = int'(CPB0);
    cpb[1]   = int'(CPB1);
    n_checks = 0;
    n_pass   = 0;
    cyc      = 0;
    n_valid[0] = 0; n_valid[1] = 0;
    last_valid[0] = 0; last_valid[1] = 0;
    rst = 1'b1;
    rx[0] = 1'b1; rx[1] = 1'b1;
    parity_en = 1'b0; even_parity = 1'b0;
    model_reset();
    #2;
    idle(3);
    lit("reset_data", int'(dout[0]), 0);
    lit("reset_busy", int'(busy[0]), 0);
    lit("reset_valid", int'(valid[1]), 0);
    rst = 1'b0;
    idle(3);

    // Plain frame, no parity: latency and contents
    v0 = n_valid[0];
    send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, sc);
    idle(4);
    lit("a5_count", n_valid[0] - v0, 1);
    lit("a5_latency", last_valid[0] - sc, 11);
    lit("a5_data", int'(dout[0]), 8'hA5);
    lit("a5_perr", int'(perr[0]), 0);
    lit("a5_ferr", int'(ferr[0]), 0);

    // Even and odd parity, correct then corrupted
    send_frame(0, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, sc);
    idle(3);
    lit("even_ok_data", int'(dout[0]), 8'h3C);
    lit("even_ok_perr", int'(perr[0]), 0);
    send_frame(0, 8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, sc);
    idle(3);
    lit("even_bad_perr", int'(perr[0]), 1);
    send_frame(0, 8'h01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, sc);
    idle(3);
    lit("odd_ok_perr", int'(perr[0]), 0);
    send_frame(0, 8'h01, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, sc);
    idle(3);
    lit("odd_bad_perr", int'(perr[0]), 1);

    // Broken stop bit followed by a held-low line
    v0 = n_valid[0];
    send_frame(0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, sc);
    for (int c = 0; c < 5; c++) step(1'b0, 1'b1);
    idle(4);
    lit("break_count", n_valid[0] - v0, 1);
    lit("break_data", int'(dout[0]), 8'hFF);
    lit("break_ferr", int'(ferr[0]), 1);
    send_frame(0, 8'h12, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, sc);
    idle(3);
    lit("after_break_data", int'(dout[0]), 8'h12);
    lit("after_break_ferr", int'(ferr[0]), 0);

    // Glitch shorter than half a bit on the slow receiver
    v1 = n_valid[1];
    for (int c = 0; c < 4; c++) step(1'b1, 1'b0);
    idle(40);
    lit("glitch_count", n_valid[1] - v1, 0);
    lit("glitch_busy", int'(busy[1]), 0);
    send_frame(1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, sc);
    idle(20);
    lit("slow_data", int'(dout[1]), 8'h5A);
    lit("slow_count", n_valid[1] - v1, 1);

    // Asynchronous reset part way through a frame
    v0 = n_valid[0];
    byte_c3 = 8'hC3;
    drive_bit(0, 1'b0);
    for (int j = 0; j < 4; j++) drive_bit(0, byte_c3[j]);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    lit("async_rst_data", int'(dout[0]), 0);
    lit("async_rst_busy", int'(busy[0]), 0);
    lit("async_rst_slow_data", int'(dout[1]), 0);
    idle(3);
    rst = 1'b0;
    idle(3);
    lit("rst_no_valid", n_valid[0] - v0, 0);
    send_frame(0, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, sc);
    idle(3);
    lit("post_rst_data", int'(dout[0]), 8'h5A);

    // Random frames, random parity mode, occasional corrupted parity, back-to-back gaps
    v0 = n_valid[0];
    for (int n = 0; n < 100; n++) begin
      rd   = 8'($urandom);
      rpe  = 1'($urandom_range(0, 1));
      rep  = 1'($urandom_range(0, 1));
      rbad = ($urandom_range(0, 7) == 0);
      send_frame(0, rd, rpe, rep, rbad, 1'b1, 1'b1, sc);
      idle(int'($urandom_range(0, 3)));
    end
    idle(4);
    lit("rand_count", n_valid[0] - v0, 100);

    v1 = n_valid[1];
    for (int n = 0; n < 8; n++) begin
      rd  = 8'($urandom);
      rpe = 1'($urandom_range(0, 1));
      rep = 1'($urandom_range(0, 1));
      send_frame(1, rd, rpe, rep, 1'b0, 1'b1, 1'b1, sc);
      idle(int'($urandom_range(0, 20)));
    end
    idle(20);
    lit("slow_rand_count", n_valid[1] - v1, 8);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
